// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: arbitrates an instruction and a data channel onto one single-port word RAM.
// Optional feature macro: MEM_INSTR_WRITE_EN (lets the instruction channel write its region).
module mem_port_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] INSTR_TOP = 'h3FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    WIN_I = 1'b0,
    WIN_D = 1'b1
  } win_e;

  win_e last_q, last_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  logic              i_rv_q, i_err_q;
  logic              d_rv_q, d_err_q;
  logic [DATA_W-1:0] i_hold_q, d_hold_q;

  logic              i_ok, d_ok;
  logic              acc_en, acc_ok, acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              ram_wr, ram_rd;

`ifndef MEM_INSTR_WRITE_EN
  // Instruction write data has no destination in this build.
  logic unused_i_wdata;
  assign unused_i_wdata = ^i_wdata;
`endif

  // Grant, fairness bookkeeping and region checks for the selected access.
  always_comb begin
    i_gnt  = 1'b0;
    d_gnt  = 1'b0;
    last_d = last_q;
    if (!rst) begin
      i_gnt = i_req & (~d_req | (last_q == WIN_D));
      d_gnt = d_req & (~i_req | (last_q == WIN_I));
    end
    if (i_req && d_req) begin
      last_d = d_gnt ? WIN_D : WIN_I;
    end

`ifdef MEM_INSTR_WRITE_EN
    i_ok = (i_addr <= INSTR_TOP);
`else
    i_ok = (i_addr <= INSTR_TOP) & ~i_we;
`endif
    d_ok = (d_addr > INSTR_TOP);

    acc_en   = i_gnt | d_gnt;
    acc_addr = d_gnt ? d_addr : i_addr;
    acc_we   = d_gnt ? d_we   : i_we;
    acc_ok   = d_gnt ? d_ok   : i_ok;
`ifdef MEM_INSTR_WRITE_EN
    acc_wdata = d_gnt ? d_wdata : i_wdata;
`else
    acc_wdata = d_wdata;
`endif

    ram_wr = acc_en & acc_ok & acc_we;
    ram_rd = acc_en & acc_ok & ~acc_we;
  end

  // Single-port RAM: contents survive reset, read data lands one cycle later.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem_q[acc_addr] <= acc_wdata;
    end
    if (ram_rd) begin
      rd_q <= mem_q[acc_addr];
    end
  end

  // Response outputs: masked during reset, zero data on illegal reads, hold otherwise.
  always_comb begin
    i_rvalid = i_rv_q & ~rst;
    d_rvalid = d_rv_q & ~rst;
    i_err    = i_err_q & ~rst;
    d_err    = d_err_q & ~rst;
    i_rdata  = i_hold_q;
    d_rdata  = d_hold_q;
    if (rst) begin
      i_rdata = '0;
      d_rdata = '0;
    end else begin
      if (i_rv_q) begin
        i_rdata = i_err_q ? '0 : rd_q;
      end
      if (d_rv_q) begin
        d_rdata = d_err_q ? '0 : rd_q;
      end
    end
  end

  // Arbiter state and per-channel response pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= WIN_I;
      i_rv_q   <= 1'b0;
      i_err_q  <= 1'b0;
      d_rv_q   <= 1'b0;
      d_err_q  <= 1'b0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      last_q   <= last_d;
      i_rv_q   <= i_gnt & ~i_we;
      i_err_q  <= i_gnt & ~i_ok;
      d_rv_q   <= d_gnt & ~d_we;
      d_err_q  <= d_gnt & ~d_ok;
      i_hold_q <= i_rdata;
      d_hold_q <= d_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed stimulus with a scoreboard for mem_port_ctrl.
// Channels 0/1 = instr/data of the default DUT, 2/3 = instr/data of the 16/8 DUT.
module tb_mem_port_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_v   [4];
  logic        we_v    [4];
  logic [11:0] addr_v  [4];
  logic [31:0] wdata_v [4];

  logic        a_i_gnt, a_i_rvalid, a_i_err, a_d_gnt, a_d_rvalid, a_d_err;
  logic [31:0] a_i_rdata, a_d_rdata;
  logic        b_i_gnt, b_i_rvalid, b_i_err, b_d_gnt, b_d_rvalid, b_d_err;
  logic [15:0] b_i_rdata, b_d_rdata;

  mem_port_ctrl u_a (
    .clk(clk), .rst(rst),
    .i_req(req_v[0]), .i_we(we_v[0]), .i_addr(addr_v[0]), .i_wdata(wdata_v[0]),
    .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata), .i_err(a_i_err),
    .d_req(req_v[1]), .d_we(we_v[1]), .d_addr(addr_v[1]), .d_wdata(wdata_v[1]),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata), .d_err(a_d_err)
  );

  mem_port_ctrl #(.DATA_W(16), .ADDR_W(8), .INSTR_TOP(8'h3F)) u_b (
    .clk(clk), .rst(rst),
    .i_req(req_v[2]), .i_we(we_v[2]), .i_addr(addr_v[2][7:0]),
    .i_wdata(wdata_v[2][15:0]),
    .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata), .i_err(b_i_err),
    .d_req(req_v[3]), .d_we(we_v[3]), .d_addr(addr_v[3][7:0]),
    .d_wdata(wdata_v[3][15:0]),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .d_err(b_d_err)
  );

  logic        gnt_s [4];
  logic        rv_s  [4];
  logic        err_s [4];
  logic [31:0] rd_s  [4];

  always_comb begin
    gnt_s[0] = a_i_gnt;  rv_s[0] = a_i_rvalid; err_s[0] = a_i_err; rd_s[0] = a_i_rdata;
    gnt_s[1] = a_d_gnt;  rv_s[1] = a_d_rvalid; err_s[1] = a_d_err; rd_s[1] = a_d_rdata;
    gnt_s[2] = b_i_gnt;  rv_s[2] = b_i_rvalid; err_s[2] = b_i_err;
    rd_s[2]  = {16'h0, b_i_rdata};
    gnt_s[3] = b_d_gnt;  rv_s[3] = b_d_rvalid; err_s[3] = b_d_err;
    rd_s[3]  = {16'h0, b_d_rdata};
  end

  logic [31:0] exp_data [4];
  bit          exp_err  [4];
  bit          exp_dc   [4];
  bit          exp_none [4];
  logic [31:0] snap     [4];

  typedef struct {
    int          cyc;
    int          ch;
    bit          rd;
    bit          err;
    bit          dc;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic chk1(string name, logic act, logic want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, want);
    end
  endtask

  // Expectation producer: every accepted access that must answer is queued.
  always @(negedge clk) begin : watch
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (req_v[c] && gnt_s[c] && !exp_none[c] && !(we_v[c] && !exp_err[c])) begin
        e.cyc  = cyc + 1;
        e.ch   = c;
        e.rd   = !we_v[c];
        e.err  = exp_err[c];
        e.dc   = exp_dc[c];
        e.data = exp_data[c];
        sbq.push_back(e);
      end
    end
  end

  // Response checker: pops the oldest expectation of a channel when it answers.
  always @(negedge clk) begin : mon
    int k;
    for (int j = sbq.size() - 1; j >= 0; j--) begin
      if (sbq[j].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_resp ch%0d: got none want response in cycle %0d",
                 sbq[j].ch, sbq[j].cyc);
        sbq.delete(j);
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (rv_s[c] || err_s[c]) begin
        k = -1;
        for (int j = 0; j < sbq.size(); j++) begin
          if (k < 0 && sbq[j].ch == c) k = j;
        end
        if (k < 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp ch%0d: got rvalid=%0b err=%0b want nothing",
                   c, rv_s[c], err_s[c]);
        end else begin
          chk($sformatf("ch%0d_resp_cycle", c), cyc, sbq[k].cyc);
          chk1($sformatf("ch%0d_rvalid", c), rv_s[c], sbq[k].rd);
          chk1($sformatf("ch%0d_err", c), err_s[c], sbq[k].err);
          if (sbq[k].dc) snap[c] = rd_s[c];
          else if (sbq[k].rd) chk($sformatf("ch%0d_rdata", c), rd_s[c], sbq[k].data);
          sbq.delete(k);
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(int c, bit w, logic [11:0] a, logic [31:0] wd,
                       logic [31:0] ed, bit ee, bit dc, bit imm);
    int n;
    req_v[c]    = 1'b1;
    we_v[c]     = w;
    addr_v[c]   = a;
    wdata_v[c]  = wd;
    exp_data[c] = ed;
    exp_err[c]  = ee;
    exp_dc[c]   = dc;
    n = 0;
    @(negedge clk);
    while (!gnt_s[c] && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!gnt_s[c]) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout ch%0d: got no gnt want gnt within 20 cycles", c);
    end else if (imm) begin
      chk($sformatf("ch%0d_gnt_wait", c), n, 0);
    end
    @(posedge clk);
    #1;
    req_v[c] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 4; c++) begin
      req_v[c] = 0; we_v[c] = 0; addr_v[c] = '0; wdata_v[c] = '0;
      exp_data[c] = '0; exp_err[c] = 0; exp_dc[c] = 0; exp_none[c] = 0;
      snap[c] = '0;
    end
    rst = 1'b1;
    idle(2);
    req_v[1] = 1'b1;
    addr_v[1] = 12'h800;
    @(negedge clk);
    chk1("gnt_during_rst", gnt_s[1], 1'b0);
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    rst = 1'b0;
    idle(1);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk1($sformatf("idle_ch%0d_gnt", c), gnt_s[c], 1'b0);
      chk1($sformatf("idle_ch%0d_rvalid", c), rv_s[c], 1'b0);
      chk1($sformatf("idle_ch%0d_err", c), err_s[c], 1'b0);
      chk($sformatf("idle_ch%0d_rdata", c), rd_s[c], 32'h0);
    end
    @(posedge clk); #1;

    issue(1, 1, 12'h400, 32'hDEADBEEF, 32'h0, 0, 0, 1);
    issue(1, 0, 12'h400, 32'h0, 32'hDEADBEEF, 0, 0, 1);
    issue(1, 1, 12'h800, 32'hA5A50800, 32'h0, 0, 0, 1);
    issue(1, 0, 12'h400, 32'h0, 32'hDEADBEEF, 0, 0, 1);
    issue(1, 0, 12'h800, 32'h0, 32'hA5A50800, 0, 0, 1);
    issue(1, 0, 12'h3FF, 32'h0, 32'h0, 1, 0, 1);
    issue(0, 0, 12'h400, 32'h0, 32'h0, 1, 0, 1);
    issue(0, 0, 12'h3FF, 32'h0, 32'h0, 0, 0, 1);

    issue(0, 0, 12'h3FF, 32'h0, 32'h0, 0, 1, 1);
    idle(2);
    issue(1, 1, 12'h3FF, ~snap[0], 32'h0, 1, 0, 1);
    idle(1);
    issue(0, 0, 12'h3FF, 32'h0, snap[0], 0, 0, 1);

`ifdef MEM_INSTR_WRITE_EN
    issue(0, 1, 12'h004, 32'h12345678, 32'h0, 0, 0, 1);
    issue(0, 0, 12'h004, 32'h0, 32'h12345678, 0, 0, 1);
`else
    issue(0, 0, 12'h004, 32'h0, 32'h0, 0, 1, 1);
    idle(2);
    issue(0, 1, 12'h004, ~snap[0], 32'h0, 1, 0, 1);
    issue(0, 0, 12'h004, 32'h0, snap[0], 0, 0, 1);
`endif
    idle(2);

    exp_none[0] = 1'b1;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 12'h010;
    @(negedge clk);
    chk1("midrst_gnt", gnt_s[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    req_v[0] = 1'b0;
    @(negedge clk);
    chk1("midrst_rvalid_n1", rv_s[0], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("midrst_rvalid_n2", rv_s[0], 1'b0);
    @(posedge clk); #1;
    exp_none[0] = 1'b0;

    rst = 1'b0;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 12'h010;
    exp_dc[0] = 1'b1; exp_err[0] = 1'b0;
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 12'h800;
    exp_dc[1] = 1'b0; exp_err[1] = 1'b0; exp_data[1] = 32'hA5A50800;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1($sformatf("rr_i_gnt_%0d", k), gnt_s[0], k[0]);
      chk1($sformatf("rr_d_gnt_%0d", k), gnt_s[1], !k[0]);
      @(posedge clk);
    end
    #1;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    idle(2);

    issue(3, 1, 12'h040, 32'h0000BEEF, 32'h0, 0, 0, 1);
    issue(3, 0, 12'h040, 32'h0, 32'h0000BEEF, 0, 0, 1);
    issue(2, 0, 12'h03F, 32'h0, 32'h0, 0, 1, 1);
    issue(2, 0, 12'h040, 32'h0, 32'h0, 1, 0, 1);
    issue(3, 0, 12'h03F, 32'h0, 32'h0, 1, 0, 1);
    idle(1);
    issue(3, 1, 12'h03F, {16'h0, ~snap[2][15:0]}, 32'h0, 1, 0, 1);
    issue(2, 0, 12'h03F, 32'h0, snap[2], 0, 0, 1);

    idle(4);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL leftover_resp: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
